// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the program-counter fetch unit.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StBoot    = 2'd0,
    StFetch   = 2'd1,
    StExecute = 2'd2,
    StHalt    = 2'd3
  } FetchState_t;

  localparam logic [1:0] INSTRUCTION_ALIGN_MASK = 2'b11;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] & INSTRUCTION_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_wait_timer.sv
// Counts fetch cycles without a memory response; flags the cycle on which the limit is reached.
module fetch_wait_timer #(
  parameter int unsigned MaxCount = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 8'd1;
    end
  end

  // High on the stalled cycle whose increment brings the count up to MaxCount.
  assign expired_o = en_i && !clr_i && (count_q == 8'(MaxCount - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Owns the architectural PC, fetches one instruction per retirement and halts on error.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter int unsigned MAX_WAIT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] programCounterInput,
  input  logic        instructionDone,
  input  logic        haltRequest,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] imemAddress,
  output logic        imemRequest,
  output logic [31:0] pcOfInstruction,
  output logic [31:0] instruction,
  output logic        instructionValid,
  output logic        halted,
  output logic        fetchMisaligned,
  output logic        fetchTimeout
);

  if (RESET_VECTOR[1:0] != 2'b00) begin : gen_bad_reset_vector
    $error("RESET_VECTOR must be word aligned");
  end
  if (MAX_WAIT_CYCLES < 1 || MAX_WAIT_CYCLES > 255) begin : gen_bad_max_wait
    $error("MAX_WAIT_CYCLES must be in 1..255");
  end

  FetchState_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        misaligned_q, misaligned_d;
  logic        timeout_q, timeout_d;

  logic in_fetch;
  logic transfer;
  logic timer_expired;

  assign in_fetch = (state_q == StFetch);
  assign transfer = in_fetch && imemReady;

  fetch_wait_timer #(
    .MaxCount (MAX_WAIT_CYCLES)
  ) u_wait_timer (
    .clk_i     (clock),
    .rst_ni    (reset),
    .clr_i     (!in_fetch || imemReady),
    .en_i      (in_fetch && !imemReady),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    misaligned_d = misaligned_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      StBoot: begin
        state_d = haltRequest ? StHalt : StFetch;
      end
      StFetch: begin
        // Halt wins over a same-cycle transfer or timeout.
        if (haltRequest) begin
          state_d = StHalt;
        end else if (transfer) begin
          instr_d = imemData;
          state_d = StExecute;
        end else if (timer_expired) begin
          timeout_d = 1'b1;
          state_d   = StHalt;
        end
      end
      StExecute: begin
        if (haltRequest) begin
          state_d = StHalt;
        end else if (instructionDone) begin
          if (is_aligned(programCounterInput)) begin
            pc_d    = programCounterInput;
            state_d = StFetch;
          end else begin
            misaligned_d = 1'b1;
            state_d      = StHalt;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StHalt;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StBoot;
      pc_q         <= RESET_VECTOR;
      instr_q      <= '0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      misaligned_q <= misaligned_d;
      timeout_q    <= timeout_d;
    end
  end

  assign imemAddress      = pc_q;
  assign imemRequest      = in_fetch;
  assign pcOfInstruction  = pc_q;
  assign instruction      = instr_q;
  assign instructionValid = (state_q == StExecute);
  assign halted           = (state_q == StHalt);
  assign fetchMisaligned  = misaligned_q;
  assign fetchTimeout     = timeout_q;

endmodule
